ctrl_decode_stage: RTL

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

---
 rtl/ctrl_decode_stage_pkg.sv | 57 +++++
 rtl/ctrl_decode_stage_comb.sv | 90 +++++++++
 rtl/ctrl_decode_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ctrl_decode_stage_pkg.sv
// rtl/ctrl_decode_stage_pkg.sv - shared opcodes, encodings, FSM states and control word
package ctrl_decode_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MEXT   = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       alu_src_a;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       illegal;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t illegal_ctrl();
    ctrl_t c;
    c         = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_comb.sv
// rtl/ctrl_decode_stage_comb.sv - purely combinational opcode to control-word decode
module ctrl_decode_comb
  import ctrl_decode_stage_pkg::*;
#(
  parameter int EN_MEXT  = 1,
  parameter int EN_AUIPC = 1
) (
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       is_div_o
);

  logic is_mext;
  assign is_mext = (funct7_i == F7_MEXT);

  always_comb begin
    ctrl_o   = '0;
    is_div_o = 1'b0;
    case (op_i)
      OP_R: begin
        if (is_mext && (EN_MEXT == 0)) begin
          ctrl_o = illegal_ctrl();
        end else begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALUOP_FUNCT;
          // funct3[2] separates DIV/DIVU/REM/REMU from the single-cycle MUL group
          is_div_o         = is_mext && funct3_i[2];
        end
      end
      OP_I: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.imm_src   = IMM_I;
        ctrl_o.alu_op    = (funct3_i == 3'b000) ? ALUOP_ADD : ALUOP_FUNCT;
      end
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_o.branch  = 1'b1;
        ctrl_o.imm_src = IMM_B;
        ctrl_o.alu_op  = ALUOP_BR;
      end
      OP_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.imm_src    = IMM_J;
        ctrl_o.result_src = RES_PC4;
      end
      OP_JALR: begin
        if (funct3_i != 3'b000) begin
          ctrl_o = illegal_ctrl();
        end else begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.jump       = 1'b1;
          ctrl_o.jump_reg   = 1'b1;
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.result_src = RES_PC4;
        end
      end
      OP_LUI: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = IMM_U;
        ctrl_o.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        if (EN_AUIPC == 0) begin
          ctrl_o = illegal_ctrl();
        end else begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.imm_src   = IMM_U;
          ctrl_o.alu_op    = ALUOP_ADD;
        end
      end
      default: ctrl_o = illegal_ctrl();
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - decode stage: handshake, registered control word, divide hold FSM
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int EN_MEXT    = 1,
  parameter int DIV_CYCLES = 4,
  parameter int EN_AUIPC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       ALUSrcA,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       JumpReg,
  output logic       Illegal,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       busy
);

  localparam int              CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_t            dec_ctrl;
  logic             dec_is_div;
  ctrl_t            ctrl_q;
  logic             out_valid_q;
  logic             busy_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;

  ctrl_decode_comb #(
    .EN_MEXT (EN_MEXT),
    .EN_AUIPC(EN_AUIPC)
  ) u_decode (
    .op_i    (op),
    .funct3_i(funct3),
    .funct7_i(funct7),
    .ctrl_o  (dec_ctrl),
    .is_div_o(dec_is_div)
  );

  assign in_ready = !rst && !flush && !busy_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q - CNT_ONE;
  end

  // Reset and flush share one path so neither can leave divide state behind
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ctrl_q      <= dec_ctrl;
            out_valid_q <= 1'b1;
            if (dec_is_div) begin
              state_q <= ST_DIV;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_LOAD;
            end
          end else if (out_valid_q && out_ready) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
          end
        end
        ST_DIV: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign RegWrite  = ctrl_q.reg_write;
  assign ALUSrc    = ctrl_q.alu_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign MemWrite  = ctrl_q.mem_write;
  assign Branch    = ctrl_q.branch;
  assign Jump      = ctrl_q.jump;
  assign JumpReg   = ctrl_q.jump_reg;
  assign Illegal   = ctrl_q.illegal;
  assign ImmSrc    = ctrl_q.imm_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUOp     = ctrl_q.alu_op;

endmodule
